// File: rtl/cb_pulse_sched_pkg.sv
// Shared items for pulse schedulers: widths, counter limits, grant record.
package cb_sched_pkg;

   localparam int N_REQ_DEF = 4;
   localparam int CNT_W_DEF = 3;
   localparam int IDX_W = (N_REQ_DEF > 1) ? $clog2(N_REQ_DEF) : 1;

   function automatic int idx_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   function automatic int cnt_max(input int w);
      return (1 << w) - 1;
   endfunction

   typedef struct packed {
      logic             valid;
      logic [IDX_W-1:0] idx;
   } grant_t;

endpackage

// File: rtl/cb_pulse_sched_if.sv
// Request/grant bundle between requesters and the pulse scheduler.
interface cb_pulse_sched_if
   import cb_sched_pkg::*;
#(
   parameter int N_REQ = N_REQ_DEF,
   parameter int CNT_W = CNT_W_DEF
);
   localparam int IW = idx_w(N_REQ);

   logic [N_REQ-1:0] REQI;
   logic             ENI;
   logic             CLRI;
   logic             ABO;
   logic [IW-1:0]    GIDO;
   logic             BUSYO;
   logic [N_REQ-1:0] OVFO;

   modport master (
      output REQI, ENI, CLRI,
      input  ABO, GIDO, BUSYO, OVFO
   );

   modport slave (
      input  REQI, ENI, CLRI,
      output ABO, GIDO, BUSYO, OVFO
   );
endinterface

// File: rtl/cb_rr_pick.sv
// Combinational round-robin picker: first pending index at or after ptr.
module cb_rr_pick
   import cb_sched_pkg::*;
#(
   parameter int N_REQ = N_REQ_DEF,
   parameter int IW    = idx_w(N_REQ)
) (
   input  logic [N_REQ-1:0] pend,
   input  logic [IW-1:0]    ptr,
   output logic             valid,
   output logic [IW-1:0]    idx
);
   int j;

   // Walk offsets high to low so the nearest one to ptr wins.
   always_comb begin
      valid = |pend;
      idx   = '0;
      j     = 0;
      for (int k = N_REQ - 1; k >= 0; k--) begin
         j = (int'(ptr) + k) % N_REQ;
         if (pend[j]) idx = IW'(j);
      end
   end
endmodule

// File: rtl/cb_pulse_sched.sv
// Merges per-requester pulse counts onto one cb_a input, one pulse per clock.
module cb_pulse_sched
   import cb_sched_pkg::*;
#(
   parameter int N_REQ = N_REQ_DEF,
   parameter int CNT_W = CNT_W_DEF
) (
   input logic              TI,
   input logic              RI,
   cb_pulse_sched_if.slave  bus
);
   localparam int IW = idx_w(N_REQ);
   localparam logic [CNT_W-1:0] CMAX = CNT_W'(cnt_max(CNT_W));
   localparam logic [IW-1:0]    LAST = IW'(N_REQ - 1);

   logic [CNT_W-1:0] cnt    [N_REQ];
   logic [CNT_W-1:0] cnt_nx [N_REQ];
   logic [N_REQ-1:0] pend;
   logic [N_REQ-1:0] ovf_set;
   logic [IW-1:0]    ptr;
   logic [IW-1:0]    idx;
   logic             any;
   logic             vld;
   logic             busy_nx;
   logic             g;

   always_comb begin
      for (int i = 0; i < N_REQ; i++) pend[i] = (cnt[i] != '0);
   end

   cb_rr_pick #(.N_REQ(N_REQ), .IW(IW)) u_pick (
      .pend  (pend),
      .ptr   (ptr),
      .valid (any),
      .idx   (idx)
   );

   assign vld = bus.ENI && any;

   // A pulse arriving at a full counter is dropped and flagged.
   always_comb begin
      busy_nx = 1'b0;
      ovf_set = '0;
      g       = 1'b0;
      for (int i = 0; i < N_REQ; i++) begin
         cnt_nx[i] = cnt[i];
         g = vld && (idx == IW'(i));
         if (bus.REQI[i] && !g) begin
            if (cnt[i] == CMAX) ovf_set[i] = 1'b1;
            else                cnt_nx[i] = cnt[i] + 1'b1;
         end else if (!bus.REQI[i] && g) begin
            cnt_nx[i] = cnt[i] - 1'b1;
         end
         busy_nx = busy_nx | (cnt_nx[i] != '0);
      end
   end

   always_ff @(posedge TI) begin
      if (RI) begin
         for (int i = 0; i < N_REQ; i++) cnt[i] <= '0;
         ptr       <= '0;
         bus.ABO   <= 1'b0;
         bus.GIDO  <= '0;
         bus.BUSYO <= 1'b0;
         bus.OVFO  <= '0;
      end else begin
         for (int i = 0; i < N_REQ; i++) cnt[i] <= cnt_nx[i];
         bus.ABO   <= vld;
         if (vld) begin
            bus.GIDO <= idx;
            ptr      <= (idx == LAST) ? '0 : idx + 1'b1;
         end
         bus.BUSYO <= busy_nx;
         bus.OVFO  <= ovf_set | (bus.CLRI ? '0 : bus.OVFO);
      end
   end
endmodule
